weight_load_arb: RTL and testbench
==================================

WEIGHT_LOAD_ARB -- requirements
Module: weight_load_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: weight RAM address width.
REQ-002 SHALL have parameter DATA_W, default 18: weight word width.
REQ-003 SHALL have parameter DEPTH, default 50176: number of words loaded per load session.
REQ-004 SHALL have ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- ld_start  in  1  pulse; begins load session at address 0.
- ld_valid  in  1  loader word valid.
- ld_ready  out  1  loader word accepted.
- ld_data  in  DATA_W  loader word.
- ld_done  out  1  one-cycle pulse after last word written.
- run_req  in  1  request inference.
- run_grant  out  1  accelerator owns RAM.
- acc_done  in  1  pulse; inference finished.
- acc_adr  in  ADDR_W  accelerator address.
- acc_d  in  DATA_W  accelerator write data.
- acc_en  in  1  accelerator enable.
- acc_we  in  1  accelerator write enable.
- acc_q  out  DATA_W  accelerator read data.
- mem_adr  out  ADDR_W  RAM address.
- mem_d  out  DATA_W  RAM write data.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_q  in  DATA_W  RAM read data, 1-cycle latency.
- err  out  1  sticky access-violation flag.
- ld_csum  out  DATA_W  load checksum.

Function
REQ-005 SHALL implement FSM with states IDLE, LOAD, READY, RUN.
- IDLE: ld_start -> LOAD.
- LOAD: last accepted word -> READY.
- READY: ld_start -> LOAD; else run_req -> RUN.
- RUN: acc_done -> READY.
REQ-006 In IDLE and READY, ld_start SHALL take priority over run_req when both are asserted in the same cycle.
REQ-007 In RUN, ld_start SHALL be ignored.
REQ-008 In LOAD, ld_start SHALL restart the session: address counter reset to 0, checksum cleared.
REQ-009 ld_ready SHALL equal 1 exactly when state is LOAD; a word is accepted when ld_valid and ld_ready are both high.
REQ-010 Each accepted word SHALL be written that cycle, combinationally: mem_en=1, mem_we=1, mem_adr=counter, mem_d=ld_data.
REQ-011 The counter SHALL increment per accepted word.
REQ-012 The word at counter DEPTH-1 SHALL be the last word: counter returns to 0, ld_done pulses high the next cycle, state becomes READY.
REQ-013 In RUN, mem_adr, mem_d, mem_en and mem_we SHALL combinationally follow acc_adr, acc_d, acc_en and acc_we.
REQ-014 acc_q SHALL always equal mem_q (no added latency).
REQ-015 run_grant SHALL be 1 exactly when state is RUN.
REQ-016 Outside RUN and outside accepted loader writes, mem_en and mem_we SHALL be 0.
REQ-017 acc_en asserted while not in RUN SHALL be blocked from the RAM and SHALL set err the next cycle; err stays set until reset.
REQ-018 acc_done outside RUN SHALL be ignored.

Reset
REQ-019 rst high SHALL asynchronously force: state IDLE, counter 0, ld_ready 0, ld_done 0, run_grant 0, err 0, ld_csum 0, mem_en 0, mem_we 0.
REQ-020 rst asserted mid-LOAD SHALL abandon the session; a fresh ld_start is required afterwards.
REQ-021 rst asserted mid-RUN SHALL revoke the grant immediately.

Configuration
REQ-022 With WLA_CHECKSUM_EN defined, ld_csum SHALL accumulate the modulo-2^DATA_W sum of accepted words, be cleared on ld_start, and hold its value from ld_done until the next ld_start.
REQ-023 Without WLA_CHECKSUM_EN, ld_csum SHALL be constant 0 and no accumulator shall exist.

Structure
REQ-024 A shared package wla_pkg SHALL hold the state enum type and the default ADDR_W, DATA_W and DEPTH constants.
REQ-025 The design SHALL be a single module with no sub-modules.

Verification
REQ-026 The bench SHALL cover these scenarios, with DEPTH=4:
- Load: ld_start, then words 1,2,3,4 with ld_valid continuous -> RAM writes at addresses 0..3; ld_done pulses 1 cycle after word 4; state READY; ld_csum=10 with macro defined, 0 without.
- Backpressure: ld_valid gaps between words -> address advances only on accepted words; ld_done timing stays relative to the 4th accepted word.
- Run: run_req in READY -> run_grant=1 next cycle; acc_adr=2, acc_en=1 -> mem_adr=2 the same cycle, acc_q=3 one cycle later; acc_done -> run_grant=0.
- Violation: acc_en=1 in IDLE -> mem_en=0 and err=1 next cycle; err remains set through a subsequent load and run.
- Priority: ld_start and run_req together in READY -> LOAD entered, run_grant stays 0.
- Reset: rst pulse after 2 words -> all outputs return to reset values; ld_start plus 4 words -> writes restart at address 0.

Source files
------------

// File: rtl/wla_pkg.sv
// Shared types and default sizing for the weight-RAM load/run arbiter.
package wla_pkg;

  localparam int unsigned WLA_ADDR_W = 16;
  localparam int unsigned WLA_DATA_W = 18;
  localparam int unsigned WLA_DEPTH  = 50176;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2,
    RUN   = 2'd3
  } state_t;

endpackage

// File: rtl/weight_load_arb_if.sv
// Loader, accelerator and RAM signal bundle for weight_load_arb.
interface weight_load_arb_if import wla_pkg::*; #(
  parameter int unsigned ADDR_W = WLA_ADDR_W,
  parameter int unsigned DATA_W = WLA_DATA_W
) ();

  logic              ld_start;
  logic              ld_valid;
  logic              ld_ready;
  logic [DATA_W-1:0] ld_data;
  logic              ld_done;
  logic              run_req;
  logic              run_grant;
  logic              acc_done;
  logic [ADDR_W-1:0] acc_adr;
  logic [DATA_W-1:0] acc_d;
  logic              acc_en;
  logic              acc_we;
  logic [DATA_W-1:0] acc_q;
  logic [ADDR_W-1:0] mem_adr;
  logic [DATA_W-1:0] mem_d;
  logic              mem_en;
  logic              mem_we;
  logic [DATA_W-1:0] mem_q;
  logic              err;
  logic [DATA_W-1:0] ld_csum;

  // Arbiter side
  modport slave (
    input  ld_start, ld_valid, ld_data, run_req, acc_done,
    input  acc_adr, acc_d, acc_en, acc_we, mem_q,
    output ld_ready, ld_done, run_grant, acc_q,
    output mem_adr, mem_d, mem_en, mem_we, err, ld_csum
  );

  // Loader, accelerator and RAM side
  modport master (
    output ld_start, ld_valid, ld_data, run_req, acc_done,
    output acc_adr, acc_d, acc_en, acc_we, mem_q,
    input  ld_ready, ld_done, run_grant, acc_q,
    input  mem_adr, mem_d, mem_en, mem_we, err, ld_csum
  );

endinterface

// File: rtl/weight_load_arb.sv
// Arbitrates the weight RAM between a sequential loader and the accelerator.
// Define WLA_CHECKSUM_EN to build the load checksum accumulator.
module weight_load_arb import wla_pkg::*; #(
  parameter int unsigned ADDR_W = WLA_ADDR_W,
  parameter int unsigned DATA_W = WLA_DATA_W,
  parameter int unsigned DEPTH  = WLA_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  weight_load_arb_if.slave  bus
);

  localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ld_done_q, ld_done_d;
  logic              err_q, err_d;
  logic              accept_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ld_done_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ld_done_q <= ld_done_d;
      err_q     <= err_d;
    end
  end

  // Next state; ld_start beats run_req and restarts an in-flight load
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ld_done_d = 1'b0;
    accept_c  = 1'b0;
    err_d     = err_q | (bus.acc_en && (state_q != RUN));
    case (state_q)
      IDLE: begin
        if (bus.ld_start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        accept_c = bus.ld_valid;
        if (bus.ld_start) begin
          cnt_d = '0;
        end else if (accept_c) begin
          if (cnt_q == LAST_ADR) begin
            cnt_d     = '0;
            ld_done_d = 1'b1;
            state_d   = READY;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end
      READY: begin
        if (bus.ld_start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end else if (bus.run_req) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.acc_done) state_d = READY;
      end
      default: state_d = IDLE;
    endcase
  end

  // RAM port mux: accelerator owns it in RUN, loader writes otherwise
  always_comb begin
    bus.mem_en  = 1'b0;
    bus.mem_we  = 1'b0;
    bus.mem_adr = cnt_q;
    bus.mem_d   = bus.ld_data;
    if (state_q == RUN) begin
      bus.mem_en  = bus.acc_en;
      bus.mem_we  = bus.acc_we;
      bus.mem_adr = bus.acc_adr;
      bus.mem_d   = bus.acc_d;
    end else if (accept_c) begin
      bus.mem_en = 1'b1;
      bus.mem_we = 1'b1;
    end
  end

  assign bus.ld_ready  = (state_q == LOAD);
  assign bus.run_grant = (state_q == RUN);
  assign bus.ld_done   = ld_done_q;
  assign bus.err       = err_q;
  assign bus.acc_q     = bus.mem_q;

`ifdef WLA_CHECKSUM_EN
  logic              restart_c;
  logic [DATA_W-1:0] csum_q;

  assign restart_c = bus.ld_start && (state_q != RUN);

  // Wraps modulo 2^DATA_W; holds after the session until the next ld_start
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            csum_q <= '0;
    else if (restart_c) csum_q <= '0;
    else if (accept_c)  csum_q <= csum_q + bus.ld_data;
  end

  assign bus.ld_csum = csum_q;
`else
  assign bus.ld_csum = DATA_W'(0);
`endif

endmodule

// File: tb/tb_weight_load_arb.sv
// Self-checking bench for weight_load_arb: directed scenarios plus randomized traffic vs a behavioural model.
module tb_weight_load_arb;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 18;
  localparam int unsigned DEPTH  = 4;
`ifdef WLA_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  localparam int M_IDLE = 0, M_LOAD = 1, M_READY = 2, M_RUN = 3;

  logic clk;
  logic rst;

  weight_load_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  weight_load_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Physical RAM driven by the DUT's memory port
  logic [DATA_W-1:0] ram [16];
  logic [DATA_W-1:0] ram_q;
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_adr[3:0]] <= bus.mem_d;
      else            ram_q <= ram[bus.mem_adr[3:0]];
    end
  end
  assign bus.mem_q = ram_q;

  // Behavioural model
  int                m_mode;
  int                m_cnt;
  logic [DATA_W-1:0] m_csum;
  bit                m_err;
  bit                m_done;
  logic [DATA_W-1:0] exp_ram [16];
  logic [DATA_W-1:0] exp_q;

  initial begin
    for (int i = 0; i < 16; i++) begin
      ram[i]     = '0;
      exp_ram[i] = '0;
    end
    ram_q = '0;
    exp_q = '0;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = M_IDLE;
      m_cnt  = 0;
      m_csum = '0;
      m_err  = 1'b0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (bus.acc_en && m_mode != M_RUN) m_err = 1'b1;
      if (m_mode == M_LOAD && bus.ld_valid) exp_ram[m_cnt % 16] = bus.ld_data;
      if (m_mode == M_RUN && bus.acc_en) begin
        if (bus.acc_we) exp_ram[bus.acc_adr[3:0]] = bus.acc_d;
        else            exp_q = exp_ram[bus.acc_adr[3:0]];
      end
      if (m_mode == M_RUN) begin
        if (bus.acc_done) m_mode = M_READY;
      end else if (bus.ld_start) begin
        m_mode = M_LOAD;
        m_cnt  = 0;
        m_csum = '0;
      end else if (m_mode == M_LOAD && bus.ld_valid) begin
        m_csum = m_csum + bus.ld_data;
        m_cnt  = m_cnt + 1;
        if (m_cnt == DEPTH) begin
          m_cnt  = 0;
          m_done = 1'b1;
          m_mode = M_READY;
        end
      end else if (m_mode == M_READY && bus.run_req) begin
        m_mode = M_RUN;
      end
    end
  end

  // Compare process: all outputs against the model every cycle
  always @(negedge clk) begin
    bit                e_en, e_we;
    logic [ADDR_W-1:0] e_adr;
    logic [DATA_W-1:0] e_d;
    e_en  = 1'b0;
    e_we  = 1'b0;
    e_adr = '0;
    e_d   = '0;
    if (m_mode == M_RUN) begin
      e_en  = bus.acc_en;
      e_we  = bus.acc_we;
      e_adr = bus.acc_adr;
      e_d   = bus.acc_d;
    end else if (m_mode == M_LOAD && bus.ld_valid) begin
      e_en  = 1'b1;
      e_we  = 1'b1;
      e_adr = ADDR_W'(m_cnt);
      e_d   = bus.ld_data;
    end
    chk("cmp_ld_ready", bus.ld_ready, m_mode == M_LOAD);
    chk("cmp_run_grant", bus.run_grant, m_mode == M_RUN);
    chk("cmp_ld_done", bus.ld_done, m_done);
    chk("cmp_err", bus.err, m_err);
    chk("cmp_ld_csum", bus.ld_csum, CSUM_ON ? m_csum : '0);
    chk("cmp_mem_en", bus.mem_en, e_en);
    chk("cmp_mem_we", bus.mem_we, e_we);
    chk("cmp_acc_q", bus.acc_q, exp_q);
    if (e_en) begin
      chk("cmp_mem_adr", bus.mem_adr, e_adr);
      chk("cmp_mem_d", bus.mem_d, e_d);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One load session of DEPTH words base..base+3, optionally with valid gaps
  task automatic load_session(input int base, input bit gaps);
    int acc = 0;
    int cyc = 0;
    bus.ld_start = 1'b1;
    step();
    bus.ld_start = 1'b0;
    while (acc < DEPTH && cyc < 40) begin
      bus.ld_valid = gaps ? ((cyc % 3) != 1) : 1'b1;
      bus.ld_data  = DATA_W'(base + acc);
      #1;
      if (bus.ld_valid) chk("ld_adr", bus.mem_adr, acc);
      chk("ld_done_early", bus.ld_done, 0);
      step();
      if (bus.ld_valid) acc++;
      cyc++;
    end
    bus.ld_valid = 1'b0;
    chk("ld_accepted", acc, DEPTH);
    chk("ld_done_pulse", bus.ld_done, 1);
    chk("ld_ready_after", bus.ld_ready, 0);
    chk("ld_csum", bus.ld_csum, CSUM_ON ? (4 * base + 6) : 0);
    for (int i = 0; i < 4; i++) chk("ld_ram", ram[i], base + i);
    step();
    chk("ld_done_clear", bus.ld_done, 0);
  endtask

  initial begin
    rst          = 1'b1;
    bus.ld_start = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
    bus.run_req  = 1'b0;
    bus.acc_done = 1'b0;
    bus.acc_adr  = '0;
    bus.acc_d    = '0;
    bus.acc_en   = 1'b0;
    bus.acc_we   = 1'b0;
    repeat (3) step();
    chk("rst_ld_ready", bus.ld_ready, 0);
    chk("rst_run_grant", bus.run_grant, 0);
    chk("rst_ld_done", bus.ld_done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_ld_csum", bus.ld_csum, 0);
    chk("rst_mem_en", bus.mem_en, 0);
    rst = 1'b0;
    step();

    // Violation in IDLE
    bus.acc_en = 1'b1;
    #1;
    chk("viol_mem_en", bus.mem_en, 0);
    step();
    bus.acc_en = 1'b0;
    chk("viol_err", bus.err, 1);

    // Plain load 1..4
    load_session(1, 1'b0);
    chk("load_err_sticky", bus.err, 1);

    // Run: read address 2
    bus.run_req = 1'b1;
    step();
    bus.run_req = 1'b0;
    chk("run_grant", bus.run_grant, 1);
    bus.acc_adr = 16'd2;
    bus.acc_en  = 1'b1;
    bus.acc_we  = 1'b0;
    #1;
    chk("run_mem_adr", bus.mem_adr, 2);
    chk("run_mem_en", bus.mem_en, 1);
    chk("run_mem_we", bus.mem_we, 0);
    step();
    bus.acc_en = 1'b0;
    chk("run_acc_q", bus.acc_q, 3);
    chk("run_err_sticky", bus.err, 1);
    bus.acc_done = 1'b1;
    step();
    bus.acc_done = 1'b0;
    chk("run_release", bus.run_grant, 0);

    // Backpressured load 5..8
    load_session(5, 1'b1);

    // Priority: ld_start beats run_req
    bus.ld_start = 1'b1;
    bus.run_req  = 1'b1;
    step();
    bus.ld_start = 1'b0;
    bus.run_req  = 1'b0;
    chk("prio_ld_ready", bus.ld_ready, 1);
    chk("prio_run_grant", bus.run_grant, 0);

    // Reset after two words
    bus.ld_valid = 1'b1;
    bus.ld_data  = 18'd9;
    step();
    bus.ld_data  = 18'd10;
    step();
    bus.ld_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mrst_ld_ready", bus.ld_ready, 0);
    chk("mrst_mem_en", bus.mem_en, 0);
    chk("mrst_err", bus.err, 0);
    chk("mrst_ld_csum", bus.ld_csum, 0);
    step();
    rst = 1'b0;
    step();
    chk("mrst_stays_idle", bus.ld_ready, 0);
    load_session(11, 1'b0);

    // Reset mid-run revokes the grant at once
    bus.run_req = 1'b1;
    step();
    bus.run_req = 1'b0;
    bus.acc_en  = 1'b1;
    chk("rrst_grant_before", bus.run_grant, 1);
    rst = 1'b1;
    #1;
    chk("rrst_grant", bus.run_grant, 0);
    chk("rrst_mem_en", bus.mem_en, 0);
    step();
    rst = 1'b0;
    bus.acc_en = 1'b0;
    step();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst          = ($urandom_range(0, 299) == 0);
      bus.ld_start = ($urandom_range(0, 15) == 0);
      bus.ld_valid = $urandom_range(0, 1) == 1;
      bus.ld_data  = DATA_W'($urandom);
      bus.run_req  = ($urandom_range(0, 3) == 0);
      bus.acc_done = ($urandom_range(0, 7) == 0);
      bus.acc_adr  = ADDR_W'($urandom_range(0, 15));
      bus.acc_d    = DATA_W'($urandom);
      bus.acc_en   = ($urandom_range(0, 2) != 0);
      bus.acc_we   = $urandom_range(0, 1) == 1;
      step();
    end
    rst = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
